// File: rtl/vga_frame_sink_pkg.sv
// Shared VGA sink constants and the frame flattening helper.
// HT and the benches also use pix_idx, so all sides agree on pixel order.
package vga_frame_sink_pkg;

    localparam int unsigned DEF_IMAGE_BITS  = 8;
    localparam int unsigned DEF_PP_MATRIX_N = 80;
    localparam int unsigned DEF_PP_MATRIX_M = 80;
    localparam int unsigned DEF_H_FP        = 8;
    localparam int unsigned DEF_H_SYNC      = 12;
    localparam int unsigned DEF_H_BP        = 20;
    localparam int unsigned DEF_V_FP        = 2;
    localparam int unsigned DEF_V_SYNC      = 2;
    localparam int unsigned DEF_V_BP        = 6;

    typedef enum logic {
        WAIT_REQ,
        ACKING
    } hs_state_t;

    // Row-major pixel index; multiply by IMAGE_BITS for the bit offset.
    function automatic int unsigned pix_idx(input int unsigned r,
                                            input int unsigned c,
                                            input int unsigned n = DEF_PP_MATRIX_N);
        return r * n + c;
    endfunction

endpackage

// File: rtl/vga_frame_sink_timing_gen.sv
// Raster counters, active-area flag, active-low syncs and end-of-frame strobe.
// All outputs are combinational views of the current counter values.
module vga_timing_gen
    import vga_frame_sink_pkg::*;
#(
    parameter int unsigned N      = DEF_PP_MATRIX_N,
    parameter int unsigned M      = DEF_PP_MATRIX_M,
    parameter int unsigned H_FP   = DEF_H_FP,
    parameter int unsigned H_SYNC = DEF_H_SYNC,
    parameter int unsigned H_BP   = DEF_H_BP,
    parameter int unsigned V_FP   = DEF_V_FP,
    parameter int unsigned V_SYNC = DEF_V_SYNC,
    parameter int unsigned V_BP   = DEF_V_BP,
    parameter int unsigned HW     = $clog2(N + H_FP + H_SYNC + H_BP),
    parameter int unsigned VW     = $clog2(M + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          eof
);

    localparam logic [HW-1:0] H_ACT  = HW'(N);
    localparam logic [HW-1:0] H_SS   = HW'(N + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(N + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST = HW'(N + H_FP + H_SYNC + H_BP - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(M);
    localparam logic [VW-1:0] V_SS   = VW'(M + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(M + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(M + V_FP + V_SYNC + V_BP - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hsync_n = !((h_cnt >= H_SS) && (h_cnt < H_SE));
        vsync_n = !((v_cnt >= V_SS) && (v_cnt < V_SE));
        eof     = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end

endmodule

// File: rtl/vga_frame_sink.sv
// Frame sink: four-phase capture from HT into a shadow buffer, promotion to the
// display buffer at frame boundaries, and registered raster scan-out.
module vga_frame_sink
    import vga_frame_sink_pkg::*;
#(
    parameter int unsigned IMAGE_BITS  = DEF_IMAGE_BITS,
    parameter int unsigned PP_MATRIX_N = DEF_PP_MATRIX_N,
    parameter int unsigned PP_MATRIX_M = DEF_PP_MATRIX_M,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP
) (
    input  logic                                          Clk,
    input  logic                                          Reset,
    input  logic                                          vgaReqOut,
    input  logic [IMAGE_BITS*PP_MATRIX_N*PP_MATRIX_M-1:0] Output,
    output logic                                          vgaAckOut,
    output logic                                          Hsync,
    output logic                                          Vsync,
    output logic                                          PixelValid,
    output logic [IMAGE_BITS-1:0]                         Pixel,
    output logic                                          FrameStart
);

    localparam int unsigned FLAT_WIDE = IMAGE_BITS * PP_MATRIX_N * PP_MATRIX_M;
    localparam int unsigned H_TOTAL   = PP_MATRIX_N + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = PP_MATRIX_M + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW        = $clog2(H_TOTAL);
    localparam int unsigned VW        = $clog2(V_TOTAL);
    localparam int unsigned PW        = $clog2(FLAT_WIDE);

    hs_state_t            state, state_nxt;
    logic                 capture;
    logic                 shadow_full, loaded;
    logic [FLAT_WIDE-1:0] shadow_buf, display_buf;
    logic [HW-1:0]        h_cnt;
    logic [VW-1:0]        v_cnt;
    logic                 active, hsync_n, vsync_n, eof;
    logic                 show;
    logic [PW-1:0]        pbase;

    vga_timing_gen #(
        .N      (PP_MATRIX_N),
        .M      (PP_MATRIX_M),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP),
        .HW     (HW),
        .VW     (VW)
    ) u_timing (
        .clk     (Clk),
        .rst_n   (Reset),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .active  (active),
        .hsync_n (hsync_n),
        .vsync_n (vsync_n),
        .eof     (eof)
    );

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            WAIT_REQ: if (vgaReqOut && !shadow_full) begin
                capture   = 1'b1;
                state_nxt = ACKING;
            end
            ACKING:   if (!vgaReqOut) state_nxt = WAIT_REQ;
            default:  state_nxt = WAIT_REQ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= WAIT_REQ;
            vgaAckOut <= 1'b0;
        end else begin
            state     <= state_nxt;
            vgaAckOut <= (state_nxt == ACKING);
        end
    end

    // Capture needs shadow_full=0 and swap needs shadow_full=1, so they never collide.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            shadow_full <= 1'b0;
            loaded      <= 1'b0;
        end else if (capture) begin
            shadow_full <= 1'b1;
        end else if (eof && shadow_full) begin
            shadow_full <= 1'b0;
            loaded      <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (capture) shadow_buf <= Output;
        if (!capture && eof && shadow_full) display_buf <= shadow_buf;
    end

    always_comb begin
        show  = active && loaded;
        pbase = PW'(pix_idx(32'(v_cnt), 32'(h_cnt), PP_MATRIX_N) * IMAGE_BITS);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Hsync      <= 1'b1;
            Vsync      <= 1'b1;
            PixelValid <= 1'b0;
            Pixel      <= '0;
            FrameStart <= 1'b0;
        end else begin
            Hsync      <= hsync_n;
            Vsync      <= vsync_n;
            PixelValid <= show;
            Pixel      <= show ? display_buf[pbase +: IMAGE_BITS] : '0;
            FrameStart <= show && (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_frame_sink.sv
// Directed bench for vga_frame_sink on a 4x4 raster (8 clocks/line, 7 lines/frame).
module tb_vga_frame_sink;
    import vga_frame_sink_pkg::*;

    logic         Clk;
    logic         Reset;
    logic         vgaReqOut;
    logic [127:0] Output;
    logic         vgaAckOut, Hsync, Vsync, PixelValid, FrameStart;
    logic [7:0]   Pixel;

    int          checks   = 0;
    int          failures = 0;
    int unsigned edges    = 0;
    logic [7:0]  pixq[$];
    logic        ackq[$];

    vga_frame_sink #(
        .IMAGE_BITS  (8),
        .PP_MATRIX_N (4),
        .PP_MATRIX_M (4),
        .H_FP        (1),
        .H_SYNC      (2),
        .H_BP        (1),
        .V_FP        (1),
        .V_SYNC      (1),
        .V_BP        (1)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .vgaReqOut  (vgaReqOut),
        .Output     (Output),
        .vgaAckOut  (vgaAckOut),
        .Hsync      (Hsync),
        .Vsync      (Vsync),
        .PixelValid (PixelValid),
        .Pixel      (Pixel),
        .FrameStart (FrameStart)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) edges = 0;
        else        edges = edges + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pixval(input int unsigned kind, input int unsigned k);
        case (kind)
            0:       return 8'(k + 1);
            1:       return 8'(k * 3 + 7);
            2:       return 8'(8'hA0 + k);
            default: return 8'(8'hF0 - k);
        endcase
    endfunction

    function automatic logic [127:0] mkframe(input int unsigned kind);
        logic [127:0] f = '0;
        for (int unsigned k = 0; k < 16; k++)
            f = f | (128'(pixval(kind, k)) << (pix_idx(k / 4, k % 4, 4) * 8));
        return f;
    endfunction

    task automatic push_frame(input int unsigned kind);
        for (int unsigned k = 0; k < 16; k++) pixq.push_back(pixval(kind, k));
    endtask

    task automatic step_ack(input logic exp);
        ackq.push_back(exp);
        @(posedge Clk);
        #1;
        chk("ack", {31'd0, vgaAckOut}, {31'd0, ackq.pop_front()});
    endtask

    task automatic run_to(input int unsigned n, input logic exp);
        int unsigned guard = 0;
        while (edges < n && guard < 1000) begin
            step_ack(exp);
            guard++;
        end
        if (edges < n) chk("run_to_timeout", edges, n);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ack"},   {31'd0, vgaAckOut},  32'd0);
        chk({tag, "_hsync"}, {31'd0, Hsync},      32'd1);
        chk({tag, "_vsync"}, {31'd0, Vsync},      32'd1);
        chk({tag, "_valid"}, {31'd0, PixelValid}, 32'd0);
        chk({tag, "_pixel"}, {24'd0, Pixel},      32'd0);
        chk({tag, "_fstart"},{31'd0, FrameStart}, 32'd0);
    endtask

    // Outputs after edge k reflect raster position (k-1) mod 56.
    always @(negedge Clk) begin : mon
        int unsigned p, h, v;
        logic        act, vexp, fexp;
        logic [7:0]  pexp;
        if (Reset && edges > 0) begin
            p    = (edges - 1) % 56;
            h    = p % 8;
            v    = p / 8;
            act  = (h < 4) && (v < 4);
            vexp = act && (pixq.size() > 0);
            pexp = 8'h00;
            fexp = 1'b0;
            if (vexp) begin
                pexp = pixq.pop_front();
                fexp = (h == 0) && (v == 0);
            end
            chk("hsync",  {31'd0, Hsync},      {31'd0, !((h >= 5) && (h <= 6))});
            chk("vsync",  {31'd0, Vsync},      {31'd0, !(v == 5)});
            chk("valid",  {31'd0, PixelValid}, {31'd0, vexp});
            chk("pixel",  {24'd0, Pixel},      {24'd0, pexp});
            chk("fstart", {31'd0, FrameStart}, {31'd0, fexp});
        end
    end

    initial begin
        Reset     = 1'b0;
        vgaReqOut = 1'b0;
        Output    = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk_reset("por");
        @(negedge Clk);
        Reset = 1'b1;

        // Idle first frame: syncs only, nothing valid.
        run_to(60, 1'b0);

        // Frame A captured at edge 61, displayed after the swap at edge 112.
        vgaReqOut = 1'b1;
        Output    = mkframe(0);
        step_ack(1'b1);
        run_to(66, 1'b1);
        vgaReqOut = 1'b0;
        step_ack(1'b0);

        // Frame B requested while shadow is full: stalls until the swap edge.
        run_to(70, 1'b0);
        vgaReqOut = 1'b1;
        Output    = mkframe(1);
        run_to(85, 1'b0);
        push_frame(0);
        run_to(112, 1'b0);
        step_ack(1'b1);
        run_to(115, 1'b1);
        vgaReqOut = 1'b0;
        step_ack(1'b0);
        run_to(141, 1'b0);
        push_frame(1);

        // Frame C first sampled on the swap edge 168: acked at 169.
        run_to(167, 1'b0);
        vgaReqOut = 1'b1;
        Output    = mkframe(2);
        step_ack(1'b0);
        step_ack(1'b1);
        vgaReqOut = 1'b0;
        step_ack(1'b0);
        run_to(197, 1'b0);
        push_frame(2);
        push_frame(2);
        push_frame(2);
        run_to(380, 1'b0);
        chk("queue_drained_1", pixq.size(), 32'd0);

        // Reset in the middle of ACKING, during a sync interval.
        vgaReqOut = 1'b1;
        Output    = mkframe(3);
        step_ack(1'b1);
        run_to(383, 1'b1);
        chk("pre_reset_hsync", {31'd0, Hsync}, 32'd0);
        chk("pre_reset_vsync", {31'd0, Vsync}, 32'd0);
        #3;
        Reset     = 1'b0;
        vgaReqOut = 1'b0;
        #1;
        chk_reset("async");
        pixq.delete();
        ackq.delete();
        repeat (2) @(posedge Clk);
        #1;
        chk_reset("held");
        @(negedge Clk);
        Reset = 1'b1;

        // Fresh request after reset; frame D shown after the swap at edge 56.
        run_to(5, 1'b0);
        vgaReqOut = 1'b1;
        step_ack(1'b1);
        vgaReqOut = 1'b0;
        step_ack(1'b0);
        run_to(29, 1'b0);
        push_frame(3);
        run_to(90, 1'b0);
        chk("queue_drained_2", pixq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_frame_sink.md
# vga_frame_sink

Downstream end of the HT output handshake: consumes the flattened post-processed frame that HT presents on `Output` under `vgaReqOut`, and answers with `vgaAckOut`. Captured frames go into a shadow buffer, are promoted to a display buffer at frame boundaries, and are scanned out one pixel per clock in raster order with VGA-style sync timing. It replaces the behavioural VGA consumer in the top-level bench and sits between HT and the display pins.

## Interface
- `IMAGE_BITS`, 8, bits per pixel
- `PP_MATRIX_N`, 80, pixels per row (active width)
- `PP_MATRIX_M`, 80, rows per frame (active height)
- `H_FP`, `H_SYNC`, `H_BP`: 8, 12, 20; horizontal porch and sync lengths in clocks
- `V_FP`, `V_SYNC`, `V_BP`: 2, 2, 6; vertical porch and sync lengths in lines
- Derived: `FLAT_WIDE = IMAGE_BITS*PP_MATRIX_N*PP_MATRIX_M`, `H_TOTAL = PP_MATRIX_N+H_FP+H_SYNC+H_BP`, `V_TOTAL = PP_MATRIX_M+V_FP+V_SYNC+V_BP`

Ports:
- `Clk` in 1: single clock, one pixel per cycle
- `Reset` in 1: asynchronous, active-low
- `vgaReqOut` in 1: HT has a frame on `Output`
- `Output` in FLAT_WIDE: frame; pixel (r,c) is `Output[(r*PP_MATRIX_N+c)*IMAGE_BITS +: IMAGE_BITS]`
- `vgaAckOut` out 1: frame captured
- `Hsync` out 1: active-low horizontal sync
- `Vsync` out 1: active-low vertical sync
- `PixelValid` out 1: active region and a frame is loaded
- `Pixel` out IMAGE_BITS: pixel value, 0 when `PixelValid`=0
- `FrameStart` out 1: one-cycle pulse with pixel (0,0)

## Operation
- Reset values: `vgaAckOut`=0, `Hsync`=1, `Vsync`=1, `PixelValid`=0, `Pixel`=0, `FrameStart`=0. Counters are 0, `shadow_full`=0, `loaded`=0, and the handshake FSM is in WAIT_REQ.
- Handshake FSM:
  - WAIT_REQ: if `vgaReqOut`=1 and `shadow_full`=0, latch `Output` into the shadow buffer, set `shadow_full`, set `vgaAckOut`=1, go to ACKING.
  - ACKING: hold `vgaAckOut`=1 until `vgaReqOut`=0, then clear `vgaAckOut` and go to WAIT_REQ. This is four-phase.
  - `vgaReqOut` high while `shadow_full`=1: no ack; HT stalls.
- Counters: `h_cnt` runs 0..H_TOTAL-1 and wraps to 0; `v_cnt` increments on each `h_cnt` wrap and wraps to 0 after V_TOTAL-1.
- Active region is `h_cnt<PP_MATRIX_N` and `v_cnt<PP_MATRIX_M`.
- `Hsync` is low for `h_cnt` in [N+H_FP, N+H_FP+H_SYNC). `Vsync` is low for `v_cnt` in [M+V_FP, M+V_FP+V_SYNC).
- Swap: on the edge where `h_cnt`=H_TOTAL-1 and `v_cnt`=V_TOTAL-1, if `shadow_full`=1 then copy shadow to display, clear `shadow_full`, and set `loaded`. Otherwise the display buffer is reshown unchanged.
- Swap and capture are never on the same edge, because capture tests the registered `shadow_full`. A request arriving on the swap edge is acked one cycle later.
- Tearing is impossible: the display buffer only changes between frames.

## Timing
- Handshake latency: `vgaAckOut` rises on the first edge after `vgaReqOut`=1 with `shadow_full`=0, and falls on the first edge after `vgaReqOut`=0.
- Scan-out outputs are registered and reflect the counters one cycle late. (r,c) is presented the cycle after `h_cnt`=c, `v_cnt`=r.
- `FrameStart` is high on the same cycle `Pixel` shows (0,0).
- A captured frame is first displayed at the next frame boundary, i.e. within one frame plus one cycle after the ack.
- Asynchronous `Reset` mid-frame or mid-handshake returns all state to reset values immediately. A partially acked transfer is discarded and HT must re-request.

## Structure
- Shared package/header: H/V timing default constants and a pixel-index function `pix_idx(r,c)`, which HT and benches also use for flattening.
- One sub-module, `vga_timing_gen`: the h/v counters, active flag, sync generation, and an end-of-frame strobe.
- The FSM, buffers and pixel mux live in the top level.

## Test plan
All scenarios use N=M=4, IMAGE_BITS=8, H 1/2/1 (H_TOTAL=8) and V 1/1/1 (V_TOTAL=7).
- Reset release with no request: `Hsync` is low at `h_cnt` 5–6 every line, `Vsync` is low on line 5, `PixelValid` stays 0, `Pixel` stays 0.
- `vgaReqOut`=1 with pixel k = k+1 at cycle 3: `vgaAckOut`=1 at cycle 4. Drop req at cycle 10: ack=0 at cycle 11. The next frame shows `Pixel` 1..16 with `FrameStart` on pixel 1 and 4 valid cycles per line.
- Second request while `shadow_full`=1: ack stays 0 until the swap edge. Ack rises the cycle after the swap, and the old frame finishes displaying intact.
- Request asserted exactly on the swap edge: ack follows one cycle later, and the new frame is shown at the following boundary.
- Reset asserted mid-line during ACKING: all outputs go to reset values asynchronously, and after release ack requires a fresh request.
- No new frame for 3 frames: the same 16 pixels repeat every 56 cycles.
